blake_ctrl: RTL
===============

Name: blake_ctrl

Overview:
- Top-level sequencer for the Blake-512 compression core.
- Accepts 16 × 64-bit message words per block over a valid/ready handshake and tracks the 128-bit bit counter t.
- Drives the datapath enables for block load, state init, the 128-step G sequence and finalization.
- Sits directly upstream of blake_counter: it generates round_ing and consumes count_done.

Parameters:
WORD_W, 64, message word width in bits
NWORDS, 16, words per message block
T_W, 128, width of bit counter t
WDOG, 140, cycles allowed in ROUND before a timeout error

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  pulse: begin a new message; next block uses IV for h
in_valid  input  1  message word valid
in_ready  output  1  message word accepted when in_valid && in_ready
in_word  input  WORD_W  message word
in_bits  input  11  message bits in the current block (0..1024), sampled with word 0
count_done  input  1  from blake_counter: counter_idx == 127
msg_we  output  1  write in_word into message register msg_widx
msg_widx  output  4  message word index 0..15
h_iv  output  1  during init_en: load h from IV (first block of a message)
init_en  output  1  one-cycle pulse: load v from h, salt, t
t_cnt  output  T_W  current bit counter
t_zero  output  1  during init_en: use t = 0 (padding-only block)
round_ing  output  1  high for each G step; drives blake_counter
final_en  output  1  one-cycle pulse: h <= h ^ s ^ v_lo ^ v_hi
out_valid  output  1  chaining value / digest ready
out_ready  input  1  consumer accepts the result
busy  output  1  high in any state except IDLE
err  output  1  sticky watchdog error; cleared by rst or start

Behaviour:
- Reset (rst = 1 at a clk edge): state = IDLE; in_ready, msg_we, init_en, round_ing, final_en, out_valid, busy, err, h_iv and t_zero all 0; t_cnt = 0; msg_widx = 0; the internal first-block flag is cleared.
- States: IDLE, LOAD, INIT, ROUND, FINAL, DONE.
- IDLE:
  - in_ready = 0.
  - start = 1: set first-block flag, t_cnt <= 0, err <= 0, go to LOAD.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready = 1. Each accepted word asserts msg_we combinationally in the same cycle, with msg_widx = current index, then the index increments.
  - in_bits is captured on acceptance of word 0.
  - Acceptance of word 15: index wraps to 0 and the state moves to INIT.
  - in_valid low stalls indefinitely; no timeout.
- INIT (1 cycle):
  - init_en = 1; h_iv = first-block flag.
  - Captured in_bits != 0: t_cnt <= t_cnt + in_bits, modulo 2^T_W, with t_zero = 0. init_en uses the updated t, so the datapath reads t_cnt + in_bits combinationally.
  - Captured in_bits == 0: t_cnt unchanged, t_zero = 1.
  - First-block flag cleared. Go to ROUND.
- ROUND:
  - round_ing = 1 every cycle.
  - Exit to FINAL on the cycle round_ing && count_done; that cycle executes step 127. Total ROUND length is exactly 128 cycles when the counter starts at 0.
  - A watchdog counts ROUND cycles. If it reaches WDOG without count_done: err <= 1, round_ing drops, go to IDLE.
- FINAL (1 cycle): final_en = 1, then go to DONE.
- DONE:
  - out_valid = 1, held until out_ready.
  - On out_valid && out_ready: go to LOAD for the next block of the same message; the first-block flag stays 0.
  - start = 1 together with out_ready: go to LOAD with the first-block flag set and t_cnt <= 0 (new message).
  - start without out_ready is ignored.
- blake_counter must be at 0 on ROUND entry. Its reset and rst derive from the same system reset. A rst mid-ROUND returns this block to IDLE; the counter is cleared by its own reset.
- count_done outside ROUND is ignored.
- Block-to-block throughput: 16 (LOAD, no stalls) + 1 + 128 + 1 + 1 (DONE with out_ready high) = 147 cycles.

Test Plan:
- Single block: rst, start, 16 words back-to-back with in_bits = 1024, model counter clean -> init_en at cycle 17 with h_iv = 1, t_cnt = 1024, t_zero = 0; round_ing high for exactly 128 cycles; final_en 1 cycle; out_valid next cycle.
- Two blocks, in_bits = 1024 then 0 -> second init_en has h_iv = 0, t_zero = 1, t_cnt stays 1024; msg_widx runs 0..15 again per block.
- Stalls: in_valid toggled randomly during LOAD, out_ready held low 10 cycles in DONE -> no word lost or duplicated (msg_we count = 16); out_valid stable for all 10 cycles; no round_ing during stalls.
- Watchdog: count_done tied 0 -> after WDOG = 140 ROUND cycles err = 1, state IDLE, busy = 0; a following start clears err.
- Reset mid-ROUND at step 60: rst pulse -> next cycle all outputs at reset values; a new start/load produces a clean 128-step ROUND.
- t wrap: preload t_cnt near 2^128 − 512 via repeated blocks (or force), in_bits = 1024 -> t_cnt wraps to 512.

Source files
------------

// File: rtl/blake_ctrl.sv
// Blake-512 block sequencer: message load handshake, bit counter t, and the
// init / 128-step G round / finalization enables for the compression datapath.
module blake_ctrl #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned NWORDS = 16,
  parameter int unsigned T_W    = 128,
  parameter int unsigned WDOG   = 140
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [10:0]       in_bits,
  input  logic              count_done,
  output logic              msg_we,
  output logic [3:0]        msg_widx,
  output logic              h_iv,
  output logic              init_en,
  output logic [T_W-1:0]    t_cnt,
  output logic              t_zero,
  output logic              round_ing,
  output logic              final_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned WdW     = $clog2(WDOG + 1);
  localparam logic [3:0]  LastIdx = 4'(NWORDS - 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(WDOG);

  typedef enum logic [2:0] {StIdle, StLoad, StInit, StRound, StFinal, StDone} state_e;

  state_e         state_q, state_d;
  logic [3:0]     widx_q, widx_d;
  logic [10:0]    bits_q, bits_d;
  logic [T_W-1:0] t_q, t_d;
  logic           first_q, first_d;
  logic           err_q, err_d;
  logic [WdW-1:0] wd_q, wd_d;

  // Word data flows straight into the datapath message register.
  logic unused_word;
  assign unused_word = ^in_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      widx_q  <= '0;
      bits_q  <= '0;
      t_q     <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      bits_q  <= bits_d;
      t_q     <= t_d;
      first_q <= first_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    bits_d    = bits_q;
    t_d       = t_q;
    first_d   = first_q;
    err_d     = err_q;
    wd_d      = wd_q;
    in_ready  = 1'b0;
    msg_we    = 1'b0;
    h_iv      = 1'b0;
    init_en   = 1'b0;
    t_zero    = 1'b0;
    round_ing = 1'b0;
    final_en  = 1'b0;
    out_valid = 1'b0;
    t_cnt     = t_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          first_d = 1'b1;
          t_d     = '0;
          err_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          msg_we = 1'b1;
          if (widx_q == 4'd0) bits_d = in_bits;
          if (widx_q == LastIdx) begin
            widx_d  = 4'd0;
            state_d = StInit;
          end else begin
            widx_d = widx_q + 4'd1;
          end
        end
      end
      StInit: begin
        init_en = 1'b1;
        h_iv    = first_q;
        t_zero  = (bits_q == 11'd0);
        // Datapath samples the already-advanced t during init_en.
        t_cnt   = t_q + T_W'(bits_q);
        t_d     = t_cnt;
        first_d = 1'b0;
        wd_d    = '0;
        state_d = StRound;
      end
      StRound: begin
        if (wd_q == WdLimit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          round_ing = 1'b1;
          wd_d      = wd_q + 1'b1;
          if (count_done) state_d = StFinal;
        end
      end
      StFinal: begin
        final_en = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StLoad;
          if (start) begin
            first_d = 1'b1;
            t_d     = '0;
            err_d   = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign msg_widx = widx_q;
  assign busy     = (state_q != StIdle);
  assign err      = err_q;

endmodule
